// File: rtl/scc_pkg.sv
// rtl/scc_pkg.sv - shared instruction/PC widths, branch opcodes and NOP default
package scc_pkg;

    localparam int INSTR_W    = 32;
    localparam int PC_W       = 32;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 25;

    localparam logic [6:0]         OP_B              = 7'b1100000;
    localparam logic [6:0]         OP_BR             = 7'b1100010;
    localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam logic [PC_W-1:0]    PC_ALIGN_MASK     = ~32'h0000_0003;

    // Unconditional branches the decoder treats as already resolved.
    function automatic logic is_branch(input logic [OPCODE_MSB-OPCODE_LSB:0] opcode);
        return (opcode == OP_B) || (opcode == OP_BR);
    endfunction

endpackage

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - first-word fall-through instruction queue between fetch and decode
module if_id_queue
    import scc_pkg::*;
#(
    parameter int                 DEPTH     = 4,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [INSTR_W-1:0]       in_instr,
    input  logic [PC_W-1:0]          in_pc,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INSTR_W-1:0]       out_instr,
    output logic [PC_W-1:0]          out_pc,
    output logic                     out_br,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int            AW   = $clog2(DEPTH);
    localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);

    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [PC_W-1:0]    pc_mem    [DEPTH];
    logic [DEPTH-1:0]   br_mem;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               push;
    logic               pop;

    // Ready depends only on occupancy so no combinational path runs back from decode.
    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; the pointers alone decide what is live.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            instr_mem[wr_ptr] <= in_instr;
            pc_mem[wr_ptr]    <= in_pc & PC_ALIGN_MASK;
            br_mem[wr_ptr]    <= is_branch(in_instr[OPCODE_MSB:OPCODE_LSB]);
        end
    end

    always_comb begin
        out_instr = NOP_INSTR;
        out_pc    = '0;
        out_br    = 1'b0;
        if (out_valid) begin
            out_instr = instr_mem[rd_ptr];
            out_pc    = pc_mem[rd_ptr];
            out_br    = br_mem[rd_ptr];
        end
    end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 Parameter SHALL be DEPTH, default 4, queue entries; power of two, 2..16.
REQ-002 Parameter SHALL be NOP_INSTR, default 32'h0000_0000, value on out_instr while empty.
REQ-003 Port SHALL be clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port SHALL be reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 Port SHALL be in_valid  input  1  fetch stage presents an instruction.
REQ-006 Port SHALL be in_ready  output  1  queue can accept an instruction this cycle.
REQ-007 Port SHALL be in_instr  input  32  fetched instruction word.
REQ-008 Port SHALL be in_pc  input  32  byte address of in_instr.
REQ-009 Port SHALL be flush  input  1  decode-stage redirect (taken conditional branch); discards contents.
REQ-010 Port SHALL be out_valid  output  1  head entry valid for decode.
REQ-011 Port SHALL be out_ready  input  1  decode consumes head entry this cycle.
REQ-012 Port SHALL be out_instr  output  32  head instruction.
REQ-013 Port SHALL be out_pc  output  32  head PC.
REQ-014 Port SHALL be out_br  output  1  head opcode [31:25] is 7'b1100000 (B) or 7'b1100010 (BR); decode treats it as already resolved.
REQ-015 Port SHALL be count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-016 Queue SHALL be FIFO, first-word fall-through: head fields driven from storage, no bypass from in_* to out_*.
REQ-017 push = in_valid & in_ready & ~flush; pop = out_valid & out_ready & ~flush.
REQ-018 in_ready SHALL equal (count != DEPTH), independent of out_ready (no combinational ready path).
REQ-019 out_valid SHALL equal (count != 0).
REQ-020 Latency: instruction pushed at edge N SHALL appear on out_* in cycle after edge N, not before.
REQ-021 Push+pop same cycle: count unchanged; both pointers advance; legal at full (pop frees, but in_ready stays 0 that cycle per REQ-018).
REQ-022 Push only: count+1; pop only: count-1; pointers wrap modulo DEPTH.
REQ-023 Stored PC SHALL have bits [1:0] forced to 2'b00.
REQ-024 out_br SHALL be computed at push time and stored with the entry.
REQ-025 Empty: out_instr = NOP_INSTR, out_pc = 0, out_br = 0.
REQ-026 flush SHALL have priority: at next edge count = 0, both pointers = 0, concurrent push and pop discarded.
REQ-027 in_valid with in_ready = 0 SHALL leave state unchanged; upstream holds the word.
REQ-028 out_ready with out_valid = 0 SHALL be ignored.

Reset
REQ-029 reset = 0 at rising edge SHALL set count = 0, read/write pointers = 0; resulting outputs out_valid = 0, in_ready = 1, out_instr = NOP_INSTR, out_pc = 0, out_br = 0.
REQ-030 Reset SHALL override flush, push and pop in same cycle; storage array need not be reset.
REQ-031 Reset asserted mid-operation SHALL discard all entries exactly as REQ-029.

Structure
REQ-032 Shared package scc_pkg SHALL hold OP_B = 7'b1100000, OP_BR = 7'b1100010, NOP_INSTR default, instruction/PC width constants.
REQ-033 No sub-module; storage array, pointers and counter inline in if_id_queue.

Verification
REQ-034 Reset then push 32'hC000_0004 @ pc 32'h10 -> next cycle out_valid=1, out_instr=32'hC000_0004, out_pc=32'h10, out_br=1, count=1.
REQ-035 DEPTH=4, out_ready=0, push 5 words -> count=4, in_ready=0 after 4th, 5th not stored; then pop 4 -> original order, count=0, out_instr=NOP_INSTR.
REQ-036 Full queue, in_valid=1, out_ready=1 for 8 cycles -> one pop per cycle, push accepted only on cycles with count<4, no word lost or duplicated.
REQ-037 count=3 with flush=1, in_valid=1, out_ready=1 -> next cycle count=0, out_valid=0, in_ready=1; pushed word absent.
REQ-038 push pc 32'h0000_0013 -> out_pc=32'h0000_0010.
REQ-039 Pointer wrap: 10 push/pop pairs at DEPTH=4 -> FIFO order preserved across wrap; reset=0 with count=2 -> count=0 next cycle.
